// File: rtl/ingress_frame_ctrl.sv
// ingress_frame_ctrl: write-side controller for the ingress frame FIFO
// (2048x20b) and its sideband FIFO (512x20b).
//   AXI-stream half-words are written straight into the frame FIFO. A good
//   tlast publishes one sideband entry holding the frame word count. A bad
//   frame (FIFO overflow, oversize, sideband full, disabled, optional runt)
//   rewinds the frame FIFO write pointer to the start of the frame.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   en                    accept new frames (sampled on a frame's first beat)
//   s_tvalid/s_tdata/s_tlast/s_tready   ingress AXI-stream slave
//   frame_wen/frame_wdata frame FIFO write (combinational, same-cycle write)
//   frame_full/frame_wptr frame FIFO status and write cursor
//   frame_wrst/frame_rst_wptr           frame FIFO write-pointer rewind
//   sb_wen/sb_wdata/sb_full             sideband FIFO write port
//   frame_count/drop_count              saturating statistics
// Build option: define INGRESS_CTRL_RUNT_DROP_EN to drop frames shorter than
// MIN_FRAME_WORDS.
module ingress_frame_ctrl #(
  parameter int unsigned MAX_FRAME_WORDS = 759,
  parameter int unsigned MIN_FRAME_WORDS = 30,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             s_tvalid,
  input  logic [15:0]      s_tdata,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic             frame_wen,
  output logic [19:0]      frame_wdata,
  input  logic             frame_full,
  input  logic [11:0]      frame_wptr,
  output logic             frame_wrst,
  output logic [11:0]      frame_rst_wptr,
  output logic             sb_wen,
  output logic [19:0]      sb_wdata,
  input  logic             sb_full,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned PTR_W = 12;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_REWIND = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  // Elaboration-time sanity on the length limits.
  if (MAX_FRAME_WORDS >= (1 << PTR_W) || MIN_FRAME_WORDS > MAX_FRAME_WORDS) begin : g_param_chk
    $error("ingress_frame_ctrl: invalid MIN/MAX_FRAME_WORDS");
  end

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_start_ptr;
  logic [PTR_W-1:0] r_len;
  logic             r_rew_to_idle;
  logic             r_s_tready;
  logic             r_frame_wrst;
  logic [PTR_W-1:0] r_frame_rst_wptr;
  logic             r_sb_wen;
  logic [19:0]      r_sb_wdata;
  logic [CNT_W-1:0] r_frame_count;
  logic [CNT_W-1:0] r_drop_count;

  logic [1:0]       w_state_nxt;
  logic [PTR_W-1:0] w_start_ptr_nxt;
  logic [PTR_W-1:0] w_len_nxt;
  logic             w_rew_to_idle_nxt;
  logic             w_wrst_nxt;
  logic [PTR_W-1:0] w_rst_wptr_nxt;
  logic             w_sb_wen_nxt;
  logic [19:0]      w_sb_wdata_nxt;
  logic             w_fc_inc;
  logic             w_dc_inc;
  logic             w_wen;
  logic             w_acc;
  logic             w_bad;
  logic             w_finish;
  logic             w_runt;
  logic             w_too_long;
  logic [PTR_W-1:0] w_beat_len;

  assign w_acc = s_tvalid & r_s_tready;

  // Length the frame reaches if the current beat is written.
  assign w_beat_len = (r_state == ST_IDLE) ? PTR_W'(1) : r_len + PTR_W'(1);
  assign w_too_long = (r_state == ST_ACTIVE) && (r_len >= PTR_W'(MAX_FRAME_WORDS));

`ifdef INGRESS_CTRL_RUNT_DROP_EN
  assign w_runt = (w_beat_len < PTR_W'(MIN_FRAME_WORDS));
`else
  assign w_runt = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_start_ptr_nxt   = r_start_ptr;
    w_len_nxt         = r_len;
    w_rew_to_idle_nxt = r_rew_to_idle;
    w_wrst_nxt        = 1'b0;
    w_rst_wptr_nxt    = r_frame_rst_wptr;
    w_sb_wen_nxt      = 1'b0;
    w_sb_wdata_nxt    = r_sb_wdata;
    w_fc_inc          = 1'b0;
    w_dc_inc          = 1'b0;
    w_wen             = 1'b0;
    w_bad             = 1'b0;
    w_finish          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (en) begin
            w_start_ptr_nxt = frame_wptr;
            w_len_nxt       = PTR_W'(1);
            if (frame_full) begin
              w_bad = 1'b1;
            end else begin
              w_wen       = 1'b1;
              w_finish    = s_tlast;
              w_state_nxt = ST_ACTIVE;
            end
          end else begin
            // Disabled frame: counted once on its first beat, never written.
            w_dc_inc    = 1'b1;
            w_state_nxt = s_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_acc) begin
          if (frame_full || w_too_long) begin
            w_bad = 1'b1;
          end else begin
            w_wen     = 1'b1;
            w_len_nxt = w_beat_len;
            w_finish  = s_tlast;
          end
        end
      end
      ST_REWIND: begin
        w_state_nxt = r_rew_to_idle ? ST_IDLE : ST_DROP;
      end
      ST_DROP: begin
        if (w_acc && s_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Last data word is written this cycle; sideband entry lands next cycle.
    if (w_finish) begin
      if (sb_full || w_runt) begin
        w_bad = 1'b1;
      end else begin
        w_sb_wen_nxt   = 1'b1;
        w_sb_wdata_nxt = {8'b0, w_beat_len};
        w_fc_inc       = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
    end

    if (w_bad) begin
      w_state_nxt       = ST_REWIND;
      w_rew_to_idle_nxt = s_tlast;
      w_wrst_nxt        = 1'b1;
      w_rst_wptr_nxt    = w_start_ptr_nxt;
      w_dc_inc          = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_ptr      <= '0;
      r_len            <= '0;
      r_rew_to_idle    <= 1'b0;
      r_s_tready       <= 1'b0;
      r_frame_wrst     <= 1'b0;
      r_frame_rst_wptr <= '0;
      r_sb_wen         <= 1'b0;
      r_sb_wdata       <= '0;
      r_frame_count    <= '0;
      r_drop_count     <= '0;
    end else begin
      r_start_ptr      <= w_start_ptr_nxt;
      r_len            <= w_len_nxt;
      r_rew_to_idle    <= w_rew_to_idle_nxt;
      // Stall the stream during the rewind cycle so no write overlaps it.
      r_s_tready       <= (w_state_nxt != ST_REWIND);
      r_frame_wrst     <= w_wrst_nxt;
      r_frame_rst_wptr <= w_rst_wptr_nxt;
      r_sb_wen         <= w_sb_wen_nxt;
      r_sb_wdata       <= w_sb_wdata_nxt;
      if (w_fc_inc && (r_frame_count != {CNT_W{1'b1}}))
        r_frame_count <= r_frame_count + CNT_W'(1);
      if (w_dc_inc && (r_drop_count != {CNT_W{1'b1}}))
        r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  assign s_tready       = r_s_tready;
  assign frame_wen      = w_wen;
  assign frame_wdata    = {4'b0, s_tdata};
  assign frame_wrst     = r_frame_wrst;
  assign frame_rst_wptr = r_frame_rst_wptr;
  assign sb_wen         = r_sb_wen;
  assign sb_wdata       = r_sb_wdata;
  assign frame_count    = r_frame_count;
  assign drop_count     = r_drop_count;

endmodule
